reg_read_arbiter: RTL and testbench
===================================

REG_READ_ARBITER -- requirements
Module: reg_read_arbiter

Interface
REQ-001 Parameter DATA_W, default 32, width of register-file read data.
REQ-002 Parameter ADDR_W, default 3, width of register-file read address (8 registers).
REQ-003 clk  input  1  single clock; all state changes on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 rd_req  input  4  per-requester read request; bit i belongs to requester i.
REQ-006 rd_addr  input  4*ADDR_W  packed register addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
REQ-007 rd_gnt  output  4  one-hot combinational grant, same cycle as request.
REQ-008 rd_valid  output  4  one-hot registered pulse; bit i high one cycle after requester i's grant.
REQ-009 rd_data  output  DATA_W  registered read data, valid while any rd_valid bit is high.
REQ-010 grant_cnt  output  16  number of grants issued since reset, saturating.
REQ-011 Addr  output  ADDR_W  address driven to the register-file read port.
REQ-012 Data  input  DATA_W  combinational read data returned by the register-file read port.

Function
REQ-013 rd_gnt SHALL have at most one bit set and SHALL be 0 when rd_req is 0 or reset is high.
REQ-014 Addr SHALL equal the granted requester's rd_addr field, and SHALL be 0 when no grant is issued.
REQ-015 Each cycle with a grant to requester i SHALL load rd_data <= Data and set rd_valid <= (1<<i) at the next edge, giving 1-cycle latency.
REQ-016 Each cycle without a grant SHALL set rd_valid to 0 at the next edge, and rd_data SHALL hold its last value.
REQ-017 A requester SHALL hold rd_req and rd_addr stable until it sees rd_gnt; the arbiter SHALL treat a request withdrawn before grant as never issued.
REQ-018 A requester whose request stays high after a grant SHALL be treated as a new request, with one read per grant.
REQ-019 The arbiter SHALL issue one grant per cycle, giving sustained throughput of one read per cycle.
REQ-020 The 2-bit priority pointer ptr SHALL start at 0, and after a grant to requester i SHALL update to (i+1) mod 4, wrapping 3->0.
REQ-021 Under round-robin, the arbiter SHALL grant the first requesting index found searching ptr, ptr+1, ... mod 4.
REQ-022 grant_cnt SHALL increment by 1 on each grant and SHALL saturate at 16'hFFFF, never wrapping.
REQ-023 Any requester with rd_req held continuously SHALL be granted within 4 cycles under round-robin.
REQ-024 A write to the register file in the same cycle SHALL NOT be forwarded; rd_data SHALL reflect Data as sampled at the grant edge.

Reset
REQ-025 While reset is high at a clock edge, the following SHALL be cleared to 0: rd_valid, rd_data, grant_cnt and ptr.
REQ-026 While reset is high, rd_gnt SHALL be 0 and Addr SHALL be 0, regardless of rd_req.
REQ-027 A grant outstanding when reset asserts SHALL be discarded, with no rd_valid pulse after reset.
REQ-028 The first grant SHALL be possible in the first cycle that reset is low.

Configuration
REQ-029 Macro ARB_ROUND_ROBIN_EN SHALL select the arbitration policy.
REQ-030 With ARB_ROUND_ROBIN_EN defined, the arbiter SHALL follow REQ-020, REQ-021 and REQ-023.
REQ-031 Without ARB_ROUND_ROBIN_EN, the arbiter SHALL use fixed priority with requester 0 highest and requester 3 lowest.
REQ-032 Without ARB_ROUND_ROBIN_EN, ptr SHALL be absent or constant 0, and the starvation bound of REQ-023 does not apply.
REQ-033 All other behaviour SHALL be identical with and without ARB_ROUND_ROBIN_EN.

Verification
REQ-034 Single request: register file r5=32'hDEADBEEF, rd_req=4'b0100, rd_addr field 2=5 -> rd_gnt=4'b0100 and Addr=5 same cycle; next cycle rd_valid=4'b0100, rd_data=32'hDEADBEEF, grant_cnt=1.
REQ-035 All requesters high for 8 cycles with RR enabled, fields = 0,1,2,3 -> grants 0,1,2,3,0,1,2,3 and rd_data = r0..r3 repeating, grant_cnt=8.
REQ-036 Same stimulus with the macro undefined -> rd_gnt=4'b0001 every cycle and requesters 1-3 are never granted.
REQ-037 Reset mid-operation: grant to requester 1 at cycle N, reset high at edge N -> rd_valid=0, rd_data=0 and grant_cnt=0 at cycle N+1, and ptr=0 afterwards.
REQ-038 Saturation: 65540 consecutive grants -> grant_cnt stops at 16'hFFFF.
REQ-039 Idle gap: rd_req=0 for 3 cycles after a grant -> rd_valid=0 and rd_data holding its last value, with Addr=0.

Source files
------------

// File: rtl/reg_read_arbiter.sv
// reg_read_arbiter: four requesters share one register-file read port.
// One grant per cycle; the granted requester's address drives Addr, and the
// returned Data is captured into rd_data with a one-cycle rd_valid pulse.
// Build option: define ARB_ROUND_ROBIN_EN for round-robin arbitration;
// left undefined, requester 0 has fixed highest priority.
module reg_read_arbiter #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [3:0]            rd_req,
    input  logic [4*ADDR_W-1:0]   rd_addr,
    output logic [3:0]            rd_gnt,
    output logic [3:0]            rd_valid,
    output logic [DATA_W-1:0]     rd_data,
    output logic [15:0]           grant_cnt,
    output logic [ADDR_W-1:0]     Addr,
    input  logic [DATA_W-1:0]     Data
);

    logic [3:0]        search_s;
    logic [1:0]        base_s;
    logic [1:0]        off_s;
    logic              hit_s;
    logic              gnt_any_s;
    logic [1:0]        gnt_idx_s;

    logic [3:0]        rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0] rd_data_q,  rd_data_d;
    logic [15:0]       grant_cnt_q, grant_cnt_d;

`ifdef ARB_ROUND_ROBIN_EN
    logic [1:0]        ptr_q, ptr_d;
    logic [7:0]        dbl_req_s;

    // Doubled request vector so a rotation by ptr is a plain part-select.
    assign dbl_req_s = {rd_req, rd_req};
`endif

    // Pick the winning requester: rotate requests so the search always starts
    // at bit 0, find the first set bit, then un-rotate by adding the base.
    always_comb begin
        search_s = rd_req;
        base_s   = 2'd0;
`ifdef ARB_ROUND_ROBIN_EN
        search_s = dbl_req_s[ptr_q +: 4];
        base_s   = ptr_q;
`endif
        hit_s = 1'b0;
        off_s = 2'd0;
        casez (search_s)
            4'b???1: begin hit_s = 1'b1; off_s = 2'd0; end
            4'b??10: begin hit_s = 1'b1; off_s = 2'd1; end
            4'b?100: begin hit_s = 1'b1; off_s = 2'd2; end
            4'b1000: begin hit_s = 1'b1; off_s = 2'd3; end
            default: begin hit_s = 1'b0; off_s = 2'd0; end
        endcase
        gnt_any_s = hit_s & ~reset;
        gnt_idx_s = base_s + off_s;
    end

    // Combinational grant and read-port address; both forced to 0 without a grant.
    always_comb begin
        rd_gnt = gnt_any_s ? (4'b0001 << gnt_idx_s) : 4'b0000;
        Addr   = gnt_any_s ? rd_addr[gnt_idx_s*ADDR_W +: ADDR_W] : {ADDR_W{1'b0}};
    end

    // Next-state: capture read data on a grant, saturate the grant counter.
    always_comb begin
        rd_valid_d  = rd_gnt;
        rd_data_d   = gnt_any_s ? Data : rd_data_q;
        grant_cnt_d = (gnt_any_s && (grant_cnt_q != 16'hFFFF)) ? (grant_cnt_q + 16'd1)
                                                                : grant_cnt_q;
`ifdef ARB_ROUND_ROBIN_EN
        ptr_d       = gnt_any_s ? (gnt_idx_s + 2'd1) : ptr_q;
`endif
    end

    // State registers with synchronous reset; reset also drops any pending pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q  <= 4'b0000;
            rd_data_q   <= {DATA_W{1'b0}};
            grant_cnt_q <= 16'd0;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= 2'd0;
`endif
        end else begin
            rd_valid_q  <= rd_valid_d;
            rd_data_q   <= rd_data_d;
            grant_cnt_q <= grant_cnt_d;
`ifdef ARB_ROUND_ROBIN_EN
            ptr_q       <= ptr_d;
`endif
        end
    end

    assign rd_valid  = rd_valid_q;
    assign rd_data   = rd_data_q;
    assign grant_cnt = grant_cnt_q;

endmodule

// File: tb/tb_reg_read_arbiter.sv
// Self-checking bench for reg_read_arbiter: directed cases plus random traffic
// compared against a cycle-level reference model of the arbitration rules.
module tb_reg_read_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 3;

    logic                clk;
    logic                reset;
    logic [3:0]          rd_req;
    logic [4*ADDR_W-1:0] rd_addr;
    logic [3:0]          rd_gnt;
    logic [3:0]          rd_valid;
    logic [DATA_W-1:0]   rd_data;
    logic [15:0]         grant_cnt;
    logic [ADDR_W-1:0]   Addr;
    logic [DATA_W-1:0]   Data;

    logic [DATA_W-1:0]   regs [8];
    logic [ADDR_W-1:0]   fields [4];

    int n_checks;
    int n_errors;

    // Reference model state
    logic [3:0]          m_valid;
    logic [DATA_W-1:0]   m_data;
    int                  m_cnt;
    int                  m_ptr;

    reg_read_arbiter #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_gnt    (rd_gnt),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .grant_cnt (grant_cnt),
        .Addr      (Addr),
        .Data      (Data)
    );

    // Behavioural register file read port
    assign Data = regs[Addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        if (obs !== exp) begin
            n_errors = n_errors + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive at negedge, check combinational outputs, clock, check state.
    task automatic step(input logic rst, input logic [3:0] req, input bit do_chk);
        bit               exp_any;
        int               exp_idx;
        logic [3:0]       exp_gnt;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_rdata;
        @(negedge clk);
        reset  = rst;
        rd_req = req;
        for (int i = 0; i < 4; i++) rd_addr[i*ADDR_W +: ADDR_W] = fields[i];
        #1;
        exp_any = 1'b0;
        exp_idx = 0;
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                int c;
                c = (m_ptr + k) % 4;
                if (!exp_any && req[c]) begin
                    exp_any = 1'b1;
                    exp_idx = c;
                end
            end
        end
        exp_gnt   = exp_any ? (4'b0001 << exp_idx) : 4'b0000;
        exp_addr  = exp_any ? fields[exp_idx] : '0;
        exp_rdata = regs[exp_addr];
        if (do_chk) begin
            check_eq("rd_gnt", 64'(rd_gnt), 64'(exp_gnt));
            check_eq("Addr",   64'(Addr),   64'(exp_addr));
        end
        @(posedge clk);
        #1;
        if (rst) begin
            m_valid = 4'b0000;
            m_data  = '0;
            m_cnt   = 0;
            m_ptr   = 0;
        end else begin
            m_valid = exp_gnt;
            if (exp_any) begin
                m_data = exp_rdata;
                if (m_cnt < 65535) m_cnt = m_cnt + 1;
`ifdef ARB_ROUND_ROBIN_EN
                m_ptr = (exp_idx + 1) % 4;
`endif
            end
        end
        if (do_chk) begin
            check_eq("rd_valid",  64'(rd_valid),  64'(m_valid));
            check_eq("rd_data",   64'(rd_data),   64'(m_data));
            check_eq("grant_cnt", 64'(grant_cnt), 64'(m_cnt));
        end
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        m_valid  = 4'b0000;
        m_data   = '0;
        m_cnt    = 0;
        m_ptr    = 0;
        reset    = 1'b1;
        rd_req   = 4'b0000;
        rd_addr  = '0;
        for (int i = 0; i < 8; i++) regs[i] = $urandom;
        for (int i = 0; i < 4; i++) fields[i] = '0;

        // Reset state
        step(1'b1, 4'b0000, 1'b1);
        step(1'b1, 4'b1111, 1'b1);

        // Single request from requester 2 reading r5
        regs[5]   = 32'hDEADBEEF;
        fields[2] = 3'd5;
        step(1'b0, 4'b0100, 1'b1);
        check_eq("single_data", 64'(rd_data), 64'h00000000DEADBEEF);
        check_eq("single_cnt",  64'(grant_cnt), 64'd1);

        // All requesters high for 8 cycles after a fresh reset
        step(1'b1, 4'b0000, 1'b1);
        for (int i = 0; i < 4; i++) fields[i] = 3'(i);
        for (int i = 0; i < 8; i++) step(1'b0, 4'b1111, 1'b1);
        check_eq("all_req_cnt", 64'(grant_cnt), 64'd8);

        // Reset mid-operation discards the outstanding grant
        step(1'b0, 4'b0010, 1'b1);
        step(1'b1, 4'b1111, 1'b1);
        check_eq("rst_valid", 64'(rd_valid),  64'd0);
        check_eq("rst_data",  64'(rd_data),   64'd0);
        check_eq("rst_cnt",   64'(grant_cnt), 64'd0);
        step(1'b0, 4'b1111, 1'b1);
        check_eq("post_rst_valid", 64'(rd_valid), 64'd1);

        // Idle gap after a grant
        fields[3] = 3'd6;
        step(1'b0, 4'b1000, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 4'b0000, 1'b1);
            check_eq("idle_data", 64'(rd_data), 64'(regs[6]));
        end

        // Random traffic with register-file churn and occasional resets
        for (int n = 0; n < 400; n++) begin
            regs[$urandom_range(0, 7)] = $urandom;
            for (int i = 0; i < 4; i++) fields[i] = 3'($urandom_range(0, 7));
            step(($urandom_range(0, 49) == 0) ? 1'b1 : 1'b0, 4'($urandom_range(0, 15)), 1'b1);
        end

        // Saturation of the grant counter
        step(1'b1, 4'b0000, 1'b1);
        for (int n = 0; n < 65540; n++) step(1'b0, 4'b0001, 1'b0);
        check_eq("sat_cnt", 64'(grant_cnt), 64'hFFFF);
        step(1'b0, 4'b0011, 1'b1);
        check_eq("sat_hold", 64'(grant_cnt), 64'hFFFF);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
